// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU and its data memory stage.
// Holds widths, the memory FSM state type and CPU opcode constants.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 64;
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_STORE  = 4'd2;
    localparam logic [3:0] OP_ADD    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_MUL    = 4'd5;
    localparam logic [3:0] OP_DIV    = 4'd6;
    localparam logic [3:0] OP_BRANCH = 4'd7;
    localparam logic [3:0] OP_BRZ    = 4'd8;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cpu_mem_array.sv
// DEPTH x DATA_W storage, one write port and one registered read port.
// Build option CPU_MEM_PARITY_EN adds a parity bit per word.
module cpu_mem_array
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [IDX_W-1:0]  raddr,
    input  logic [DATA_W-1:0] wdata,
`ifdef CPU_MEM_PARITY_EN
    input  logic              par_flip,
    output logic              par_err,
`endif
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value between reads; the array itself has no reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

`ifdef CPU_MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            par_mem[waddr] <= even_par(wdata) ^ par_flip;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= re && (even_par(mem[raddr]) != par_mem[raddr]);
        end
    end
`endif

endmodule

// File: rtl/cpu_mem_unit.sv
// Handshaked data memory stage with configurable wait states.
// Build option CPU_MEM_PARITY_EN adds par_inject / par_err.
module cpu_mem_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
`ifdef CPU_MEM_PARITY_EN
    input  logic              par_inject,
    output logic              par_err,
`endif
    output logic              busy
);

    // Counter runs one past WAIT_STATES so done lands 2+WAIT_STATES after accept.
    localparam logic [4:0] LAST = 5'(WAIT_STATES + 1);

    state_t            state;
    logic [4:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rd_q;
    logic              wr_q;
    logic              err_q;
    logic              last;
    logic              legal;
    logic              we;
    logic              re;

    assign last  = (state == WAIT) && (cnt == LAST);
    assign legal = (addr_q < ADDR_W'(DEPTH)) && (rd_q ^ wr_q);
    assign we    = reset_n && last && legal && wr_q;
    assign re    = reset_n && last && legal && rd_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= WAIT;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        addr_q    <= addr;
                        data_q    <= wdata;
                        rd_q      <= rd;
                        wr_q      <= wr;
                    end
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        state <= RESP;
                        done  <= 1'b1;
                        err_q <= !legal;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    err_q     <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CPU_MEM_PARITY_EN
    logic inj_q;
    logic par_hit;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            inj_q <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            inj_q <= par_inject;
        end
    end

    assign par_err = par_hit;
    assign err     = err_q | par_hit;
`else
    assign err = err_q;
`endif

    cpu_mem_array u_array (
        .clock    (clock),
        .reset_n  (reset_n),
        .we       (we),
        .re       (re),
        .waddr    (addr_q[IDX_W-1:0]),
        .raddr    (addr_q[IDX_W-1:0]),
        .wdata    (data_q),
`ifdef CPU_MEM_PARITY_EN
        .par_flip (inj_q),
        .par_err  (par_hit),
`endif
        .rdata    (rdata)
    );

endmodule
